// File: rtl/dcache_pkg.sv
// Package for the data-cache miss/writeback sequencer.
// Holds the default widths, the memory command encoding, the controller state
// type and a saturating-increment helper for the optional statistics counters.
package dcache_pkg;

  localparam int DC_ADDR_W    = 32;
  localparam int DC_BLOCK_W   = 64;
  localparam int DC_OFFSET_W  = 3;
  localparam int DC_INDEX_W   = 6;
  localparam int DC_TAG_W     = DC_ADDR_W - DC_INDEX_W - DC_OFFSET_W;
  localparam int DC_MEM_TAG_W = 4;
  localparam int DC_STAT_W    = 32;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    FILL_REQ,
    FILL_WAIT,
    INSTALL,
    RESPOND
  } ctrl_state_t;

  function automatic logic [DC_STAT_W-1:0] sat_inc(input logic [DC_STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dcache_ctrl_stats.sv
// Saturating event counters for the data-cache controller.
// Ports:
//   clock, reset_n           rising-edge clock, synchronous active-low reset
//   hit_inc, miss_inc, wb_inc one-cycle increment strobes
//   stat_hits, stat_misses, stat_writebacks  32-bit saturating counts
module dcache_ctrl_stats
  import dcache_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 hit_inc,
  input  logic                 miss_inc,
  input  logic                 wb_inc,
  output logic [DC_STAT_W-1:0] stat_hits,
  output logic [DC_STAT_W-1:0] stat_misses,
  output logic [DC_STAT_W-1:0] stat_writebacks
);

  logic [DC_STAT_W-1:0] hits_q, hits_d;
  logic [DC_STAT_W-1:0] misses_q, misses_d;
  logic [DC_STAT_W-1:0] wbs_q, wbs_d;

  always_comb begin
    hits_d   = hit_inc  ? sat_inc(hits_q)   : hits_q;
    misses_d = miss_inc ? sat_inc(misses_q) : misses_q;
    wbs_d    = wb_inc   ? sat_inc(wbs_q)    : wbs_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
      wbs_q    <= wbs_d;
    end
  end

  always_comb begin
    stat_hits       = hits_q;
    stat_misses     = misses_q;
    stat_writebacks = wbs_q;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Miss/writeback sequencer between the processor load/store port, the 2-way
// dcachemem array and tagged main memory. One whole-block request at a time:
// lookup, optional dirty-victim writeback, fill, install, respond.
// Ports:
//   clock, reset_n                      clock, synchronous active-low reset
//   proc_req_*/proc_addr/proc_wdata     processor request (valid/ready)
//   proc_resp_valid/proc_rdata          one-cycle completion pulse + load data
//   cm_*                                cache array request / lookup results
//   mem_cmd/mem_addr/mem_wdata          memory command (dcache_pkg::mem_cmd_t)
//   mem_resp/mem_tag/mem_rdata          memory accept tag, return tag, data
// Optional: define DCACHE_CTRL_STATS_EN to add stat_hits, stat_misses and
// stat_writebacks (32-bit saturating counters).
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W    = DC_ADDR_W,
  parameter int BLOCK_W   = DC_BLOCK_W,
  parameter int OFFSET_W  = DC_OFFSET_W,
  parameter int INDEX_W   = DC_INDEX_W,
  parameter int TAG_W     = ADDR_W - INDEX_W - OFFSET_W,
  parameter int MEM_TAG_W = DC_MEM_TAG_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 proc_req_valid,
  output logic                 proc_req_ready,
  input  logic                 proc_req_write,
  input  logic [ADDR_W-1:0]    proc_addr,
  input  logic [BLOCK_W-1:0]   proc_wdata,
  output logic                 proc_resp_valid,
  output logic [BLOCK_W-1:0]   proc_rdata,
  output logic                 cm_read_enable,
  output logic                 cm_write_enable,
  output logic                 cm_fill_en,
  output logic                 cm_fill_dirty,
  output logic [TAG_W-1:0]     cm_tag,
  output logic [INDEX_W-1:0]   cm_index,
  output logic [BLOCK_W-1:0]   cm_data_in,
  input  logic [BLOCK_W-1:0]   cm_data_out,
  input  logic                 cm_miss,
  input  logic                 cm_dirty,
  input  logic [TAG_W-1:0]     cm_dirty_tag,
  input  logic [INDEX_W-1:0]   cm_dirty_index,
  output logic [1:0]           mem_cmd,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [BLOCK_W-1:0]   mem_wdata,
  input  logic [MEM_TAG_W-1:0] mem_resp,
  input  logic [MEM_TAG_W-1:0] mem_tag,
  input  logic [BLOCK_W-1:0]   mem_rdata
`ifdef DCACHE_CTRL_STATS_EN
  ,
  output logic [DC_STAT_W-1:0] stat_hits,
  output logic [DC_STAT_W-1:0] stat_misses,
  output logic [DC_STAT_W-1:0] stat_writebacks
`endif
);

  ctrl_state_t           state_q, state_d;
  logic                  write_q, write_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [INDEX_W-1:0]    index_q, index_d;
  logic [BLOCK_W-1:0]    wdata_q, wdata_d;
  // Shared holding register: hit data, then victim data, then fill data.
  // The three uses never overlap within one request.
  logic [BLOCK_W-1:0]    data_q, data_d;
  logic [TAG_W-1:0]      vtag_q, vtag_d;
  logic [INDEX_W-1:0]    vindex_q, vindex_d;
  logic [MEM_TAG_W-1:0]  mtag_q, mtag_d;
  mem_cmd_t              mem_cmd_c;

  // Accesses are whole-block; the offset bits carry no information.
  logic unused_offset;
  always_comb unused_offset = ^proc_addr[OFFSET_W-1:0];

  always_comb begin
    state_d         = state_q;
    write_d         = write_q;
    tag_d           = tag_q;
    index_d         = index_q;
    wdata_d         = wdata_q;
    data_d          = data_q;
    vtag_d          = vtag_q;
    vindex_d        = vindex_q;
    mtag_d          = mtag_q;
    proc_req_ready  = 1'b0;
    proc_resp_valid = 1'b0;
    proc_rdata      = '0;
    cm_read_enable  = 1'b0;
    cm_write_enable = 1'b0;
    cm_fill_en      = 1'b0;
    cm_fill_dirty   = 1'b0;
    cm_tag          = '0;
    cm_index        = '0;
    cm_data_in      = '0;
    mem_cmd_c       = MEM_NONE;
    mem_addr        = '0;
    mem_wdata       = '0;

    // Outputs are forced to zero while reset is asserted, whatever the
    // registered state happens to be in that cycle.
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          proc_req_ready = 1'b1;
          if (proc_req_valid) begin
            write_d = proc_req_write;
            tag_d   = proc_addr[ADDR_W-1 -: TAG_W];
            index_d = proc_addr[OFFSET_W +: INDEX_W];
            wdata_d = proc_wdata;
            state_d = LOOKUP;
          end
        end
        LOOKUP: begin
          cm_tag          = tag_q;
          cm_index        = index_q;
          cm_read_enable  = !write_q;
          cm_write_enable = write_q;
          cm_data_in      = wdata_q;
          if (!cm_miss) begin
            if (!write_q) data_d = cm_data_out;
            state_d = RESPOND;
          end else if (cm_dirty) begin
            data_d   = cm_data_out;
            vtag_d   = cm_dirty_tag;
            vindex_d = cm_dirty_index;
            state_d  = WB_REQ;
          end else begin
            state_d = write_q ? INSTALL : FILL_REQ;
          end
        end
        WB_REQ: begin
          mem_cmd_c = MEM_STORE;
          mem_addr  = {vtag_q, vindex_q, {OFFSET_W{1'b0}}};
          mem_wdata = data_q;
          if (mem_resp != '0) state_d = write_q ? INSTALL : FILL_REQ;
        end
        FILL_REQ: begin
          mem_cmd_c = MEM_LOAD;
          mem_addr  = {tag_q, index_q, {OFFSET_W{1'b0}}};
          if (mem_resp != '0) begin
            mtag_d  = mem_resp;
            state_d = FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (mtag_q != '0 && mem_tag == mtag_q) begin
            data_d  = mem_rdata;
            mtag_d  = '0;
            state_d = INSTALL;
          end
        end
        INSTALL: begin
          cm_fill_en    = 1'b1;
          cm_fill_dirty = write_q;
          cm_tag        = tag_q;
          cm_index      = index_q;
          cm_data_in    = write_q ? wdata_q : data_q;
          state_d       = RESPOND;
        end
        RESPOND: begin
          proc_resp_valid = 1'b1;
          proc_rdata      = write_q ? '0 : data_q;
          state_d         = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb mem_cmd = mem_cmd_c;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      tag_q    <= '0;
      index_q  <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      vtag_q   <= '0;
      vindex_q <= '0;
      mtag_q   <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      tag_q    <= tag_d;
      index_q  <= index_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      vtag_q   <= vtag_d;
      vindex_q <= vindex_d;
      mtag_q   <= mtag_d;
    end
  end

`ifdef DCACHE_CTRL_STATS_EN
  logic hit_inc, miss_inc, wb_inc;

  always_comb begin
    hit_inc  = reset_n && (state_q == LOOKUP) && !cm_miss;
    miss_inc = reset_n && (state_q == LOOKUP) && cm_miss;
    wb_inc   = reset_n && (state_q == WB_REQ) && (mem_resp != '0);
  end

  dcache_ctrl_stats u_stats (
    .clock           (clock),
    .reset_n         (reset_n),
    .hit_inc         (hit_inc),
    .miss_inc        (miss_inc),
    .wb_inc          (wb_inc),
    .stat_hits       (stat_hits),
    .stat_misses     (stat_misses),
    .stat_writebacks (stat_writebacks)
  );
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl. The bench plays both the
// cache array and main memory, driving lookup results and memory responses
// cycle by cycle. Define DCACHE_CTRL_STATS_EN to also check the counters.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  localparam int AW  = 32;
  localparam int BW  = 64;
  localparam int OW  = 3;
  localparam int IW  = 6;
  localparam int TW  = AW - IW - OW;
  localparam int MTW = 4;

  localparam logic [BW-1:0] D_AA  = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [BW-1:0] D_55  = 64'h5555_5555_5555_5555;
  localparam logic [BW-1:0] D_0F  = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [BW-1:0] D_FL  = 64'h1234_5678_9ABC_DEF0;
  localparam logic [BW-1:0] D_BAD = 64'hDEAD_BEEF_DEAD_BEEF;

  logic           clock;
  logic           reset_n;
  logic           proc_req_valid, proc_req_ready, proc_req_write;
  logic [AW-1:0]  proc_addr;
  logic [BW-1:0]  proc_wdata;
  logic           proc_resp_valid;
  logic [BW-1:0]  proc_rdata;
  logic           cm_read_enable, cm_write_enable, cm_fill_en, cm_fill_dirty;
  logic [TW-1:0]  cm_tag;
  logic [IW-1:0]  cm_index;
  logic [BW-1:0]  cm_data_in, cm_data_out;
  logic           cm_miss, cm_dirty;
  logic [TW-1:0]  cm_dirty_tag;
  logic [IW-1:0]  cm_dirty_index;
  logic [1:0]     mem_cmd;
  logic [AW-1:0]  mem_addr;
  logic [BW-1:0]  mem_wdata;
  logic [MTW-1:0] mem_resp, mem_tag;
  logic [BW-1:0]  mem_rdata;
`ifdef DCACHE_CTRL_STATS_EN
  logic [31:0]    stat_hits, stat_misses, stat_writebacks;
`endif

  dcache_ctrl #(
    .ADDR_W(AW), .BLOCK_W(BW), .OFFSET_W(OW), .INDEX_W(IW), .TAG_W(TW), .MEM_TAG_W(MTW)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .proc_req_valid(proc_req_valid), .proc_req_ready(proc_req_ready),
    .proc_req_write(proc_req_write), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_resp_valid(proc_resp_valid), .proc_rdata(proc_rdata),
    .cm_read_enable(cm_read_enable), .cm_write_enable(cm_write_enable),
    .cm_fill_en(cm_fill_en), .cm_fill_dirty(cm_fill_dirty),
    .cm_tag(cm_tag), .cm_index(cm_index), .cm_data_in(cm_data_in),
    .cm_data_out(cm_data_out), .cm_miss(cm_miss), .cm_dirty(cm_dirty),
    .cm_dirty_tag(cm_dirty_tag), .cm_dirty_index(cm_dirty_index),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_tag(mem_tag), .mem_rdata(mem_rdata)
`ifdef DCACHE_CTRL_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_writebacks(stat_writebacks)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Presents one request in IDLE; returns just after the edge into LOOKUP.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] d);
    proc_req_valid = 1'b1;
    proc_req_write = w;
    proc_addr      = a;
    proc_wdata     = d;
    settle();
    check("accept_ready", proc_req_ready, 1);
    next_cycle();
    proc_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 0; proc_req_valid = 0; proc_req_write = 0; proc_addr = '0; proc_wdata = '0;
    cm_data_out = '0; cm_miss = 0; cm_dirty = 0; cm_dirty_tag = '0; cm_dirty_index = '0;
    mem_resp = '0; mem_tag = '0; mem_rdata = '0;

    // Reset
    next_cycle(); settle();
    check("rst_ready", proc_req_ready, 0);
    check("rst_cmd", mem_cmd, 0);
    check("rst_resp", proc_resp_valid, 0);
    next_cycle(); reset_n = 1; settle();
    check("idle_ready", proc_req_ready, 1);

    // Read 0x100: clean miss, fill via tag 3 (tag 2 returned first is ignored)
    issue(0, 32'h100, '0);
    cm_miss = 1; cm_dirty = 0; settle();
    check("a_lk_re", cm_read_enable, 1);
    check("a_lk_we", cm_write_enable, 0);
    check("a_lk_index", cm_index, 32);
    check("a_lk_tag", cm_tag, 0);
    check("a_lk_ready", proc_req_ready, 0);
    next_cycle(); cm_miss = 0; settle();
    check("a_fr_cmd", mem_cmd, MEM_LOAD);
    check("a_fr_addr", mem_addr, 32'h100);
    mem_resp = 3;
    next_cycle(); mem_resp = 0; mem_tag = 2; mem_rdata = D_BAD; settle();
    check("a_fw_cmd", mem_cmd, MEM_NONE);
    next_cycle(); mem_tag = 3; mem_rdata = D_AA; settle();
    check("a_fw_tag2_ignored", cm_fill_en, 0);
    next_cycle(); mem_tag = 0; mem_rdata = '0; settle();
    check("a_in_fill", cm_fill_en, 1);
    check("a_in_data", cm_data_in, D_AA);
    check("a_in_dirty", cm_fill_dirty, 0);
    check("a_in_index", cm_index, 32);
    next_cycle(); settle();
    check("a_rsp_valid", proc_resp_valid, 1);
    check("a_rsp_data", proc_rdata, D_AA);
    next_cycle(); settle();
    check("a_idle_resp", proc_resp_valid, 0);

    // Read 0x100 again: hit, response two cycles after accept
    issue(0, 32'h100, '0);
    cm_miss = 0; cm_data_out = D_AA; settle();
    check("b_lk_resp", proc_resp_valid, 0);
    check("b_lk_cmd", mem_cmd, MEM_NONE);
    next_cycle(); settle();
    check("b_rsp_valid", proc_resp_valid, 1);
    check("b_rsp_data", proc_rdata, D_AA);
    check("b_rsp_cmd", mem_cmd, MEM_NONE);
    next_cycle();

    // Write hit 0x100
    issue(1, 32'h100, D_55);
    cm_miss = 0; settle();
    check("c_lk_we", cm_write_enable, 1);
    check("c_lk_re", cm_read_enable, 0);
    check("c_lk_data", cm_data_in, D_55);
    next_cycle(); settle();
    check("c_rsp_valid", proc_resp_valid, 1);
    check("c_rsp_data", proc_rdata, 0);
    next_cycle();

    // Read 0x300 (same set, tag 1): dirty victim 0x100 written back first
    issue(0, 32'h300, '0);
    cm_miss = 1; cm_dirty = 1; cm_dirty_tag = '0; cm_dirty_index = 6'd32; cm_data_out = D_55;
    next_cycle(); cm_miss = 0; cm_dirty = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("c_wb_cmd", mem_cmd, MEM_STORE);
      check("c_wb_addr", mem_addr, 32'h100);
      check("c_wb_data", mem_wdata, D_55);
      next_cycle();
    end
    mem_resp = 3; settle();
    check("c_wb_acc_cmd", mem_cmd, MEM_STORE);
    next_cycle(); mem_resp = 0; settle();
    check("c_fr_cmd", mem_cmd, MEM_LOAD);
    check("c_fr_addr", mem_addr, 32'h300);
    mem_resp = 3;
    next_cycle(); mem_resp = 0; mem_tag = 3; mem_rdata = D_FL;
    next_cycle(); mem_tag = 0; mem_rdata = '0; settle();
    check("c_in_fill", cm_fill_en, 1);
    check("c_in_tag", cm_tag, 1);
    check("c_in_data", cm_data_in, D_FL);
    check("c_in_dirty", cm_fill_dirty, 0);
    next_cycle(); settle();
    check("c_rsp_valid", proc_resp_valid, 1);
    check("c_rsp_data", proc_rdata, D_FL);
    next_cycle();
`ifdef DCACHE_CTRL_STATS_EN
    check("st_hits", stat_hits, 2);
    check("st_misses", stat_misses, 2);
    check("st_wbs", stat_writebacks, 1);
`endif

    // Write miss on a clean set (0x48: index 9, tag 0): no memory traffic
    issue(1, 32'h48, D_0F);
    cm_miss = 1; cm_dirty = 0; settle();
    check("d_lk_cmd", mem_cmd, MEM_NONE);
    next_cycle(); cm_miss = 0; settle();
    check("d_in_fill", cm_fill_en, 1);
    check("d_in_dirty", cm_fill_dirty, 1);
    check("d_in_data", cm_data_in, D_0F);
    check("d_in_index", cm_index, 9);
    check("d_in_cmd", mem_cmd, MEM_NONE);
    next_cycle(); settle();
    check("d_rsp_valid", proc_resp_valid, 1);
    check("d_rsp_data", proc_rdata, 0);
    next_cycle();
`ifdef DCACHE_CTRL_STATS_EN
    check("st_misses2", stat_misses, 3);
`endif

    // Reset during FILL_WAIT; the late return must be dropped
    issue(0, 32'h100, '0);
    cm_miss = 1; cm_dirty = 0;
    next_cycle(); cm_miss = 0; mem_resp = 5;
    next_cycle(); mem_resp = 0; reset_n = 0; settle();
    check("e_rst_ready", proc_req_ready, 0);
    check("e_rst_cmd", mem_cmd, MEM_NONE);
    next_cycle(); reset_n = 1; settle();
    check("e_idle_ready", proc_req_ready, 1);
    check("e_idle_cmd", mem_cmd, MEM_NONE);
    check("e_idle_fill", cm_fill_en, 0);
    mem_tag = 5; mem_rdata = D_BAD;
    next_cycle(); mem_tag = 0; settle();
    check("e_late_fill", cm_fill_en, 0);
    check("e_late_resp", proc_resp_valid, 0);
    check("e_late_ready", proc_req_ready, 1);
    next_cycle(); settle();
    check("e_late_resp2", proc_resp_valid, 0);
`ifdef DCACHE_CTRL_STATS_EN
    check("st_rst_hits", stat_hits, 0);
    check("st_rst_misses", stat_misses, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
